// File: rtl/rr_sched416_pkg.sv
// Shared constants and state encoding for the
// 16-way round-robin grant scheduler.
package rr_sched416_pkg;

  localparam int NREQ = 16;
  localparam int IW   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_sched416_decode.sv
// 4->16 one-hot decoder; output bit k is high
// when the binary input equals k.
module decode416
  import rr_sched416_pkg::*;
(
  input  logic [IW-1:0]   a_i,
  output logic [0:NREQ-1] y_o
);

  always_comb begin
    y_o      = '0;
    y_o[a_i] = 1'b1;
  end

endmodule

// File: rtl/rr_sched416.sv
// Round-robin scheduler: one owner of a shared
// resource at a time, bounded hold, one-hot grant.
module rr_sched416
  import rr_sched416_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [0:NREQ-1] req,
  input  logic            rel,
  output logic [0:NREQ-1] gnt,
  output logic [0:IW-1]   gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic          to_q, to_d;
  logic [IW-1:0] pick;
  logic          found;
  logic          hit_max;
  logic          end_c;
  logic [0:NREQ-1] dec;

  // Scan last+1 .. last (wrapping); the first hit wins.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[last_q + IW'(i)]) begin
        found = 1'b1;
        pick  = last_q + IW'(i);
      end
    end
  end

  assign hit_max = (cnt_q == HOLD_MAX);
  assign end_c   = rel | ~req[idx_q] | hit_max;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = pick;
          last_d  = pick;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (end_c) begin
          state_d = IDLE;
          // Timeout only when the limit alone ended it.
          to_d    = hit_max & ~rel & req[idx_q];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      to_q    <= to_d;
    end
  end

  decode416 u_dec (
    .a_i (idx_q),
    .y_o (dec)
  );

  assign gnt_vld = (state_q == GRANT);
  assign timeout = to_q;
  assign gnt     = dec & {NREQ{gnt_vld}};

  // gnt_idx[0] carries the LSB.
  always_comb begin
    for (int b = 0; b < IW; b++) begin
      gnt_idx[b] = idx_q[b];
    end
  end

endmodule

// File: tb/tb_rr_sched416.sv
// Self-checking bench for rr_sched416: directed
// vector table plus random traffic vs a model.
module tb_rr_sched416;

  localparam int MAXH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:15] req;
  logic        rel;
  logic [0:15] gnt;
  logic [0:3]  gnt_idx;
  logic        gnt_vld;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_sched416 #(.MAX_HOLD(MAXH), .CW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    logic [0:15] q;
    bit          l;
    bit          ev;
    int          ei;
    bit          et;
  } vec_t;

  vec_t tbl[$];

  // Reference model: owner / hold count / last
  int m_busy, m_owner, m_hold, m_last;
  bit m_to;

  task automatic model_edge(bit r, logic [0:15] q, bit l);
    bit e;
    if (r) begin
      m_busy = 0; m_owner = 0; m_hold = 0;
      m_last = 15; m_to = 0;
    end else if (m_busy != 0) begin
      e    = l || !q[m_owner] || (m_hold == MAXH);
      m_to = (m_hold == MAXH) && !l && q[m_owner];
      if (e) m_busy = 0;
      else m_hold++;
    end else begin
      m_to = 0;
      for (int i = 1; i <= 16; i++) begin
        int k;
        k = (m_last + i) % 16;
        if (q[k]) begin
          m_owner = k; m_last = k;
          m_busy = 1; m_hold = 1;
          break;
        end
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int dut_idx();
    return {gnt_idx[3], gnt_idx[2], gnt_idx[1], gnt_idx[0]};
  endfunction

  task automatic chk_all(string tag, bit ev, int ei, bit et);
    logic [0:15] eg;
    eg = '0;
    if (ev) eg[ei] = 1'b1;
    chk({tag, ".vld"}, int'(gnt_vld), int'(ev));
    chk({tag, ".idx"}, dut_idx(), ei);
    chk({tag, ".to"}, int'(timeout), int'(et));
    chk({tag, ".gnt"}, int'(gnt), int'(eg));
  endtask

  task automatic step(bit r, logic [0:15] q, bit l);
    rst = r; req = q; rel = l;
    @(posedge clk);
    model_edge(r, q, l);
    #1;
  endtask

  task automatic add(bit r, logic [0:15] q, bit l,
                     bit ev, int ei, bit et);
    vec_t v;
    v.r = r; v.q = q; v.l = l;
    v.ev = ev; v.ei = ei; v.et = et;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; req = '0; rel = 1'b0;
    m_busy = 0; m_owner = 0; m_hold = 0;
    m_last = 15; m_to = 0;

    // Reset with all requesting, first grant idx 0
    add(1, 16'hFFFF, 0, 0, 0, 0);
    add(1, 16'hFFFF, 0, 0, 0, 0);
    add(0, 16'hFFFF, 0, 1, 0, 0);
    // Rotation 1..15 then 0
    for (int k = 1; k <= 16; k++) begin
      add(0, 16'hFFFF, 1, 0, k - 1, 0);
      add(0, 16'hFFFF, 0, 1, k % 16, 0);
    end
    add(0, 16'hFFFF, 1, 0, 0, 0);
    // Timeout: req[5] only, 8 cycles held
    add(0, 16'h0400, 0, 1, 5, 0);
    for (int c = 0; c < 7; c++) add(0, 16'h0400, 0, 1, 5, 0);
    add(0, 16'h0400, 0, 0, 5, 1);
    add(0, 16'h0400, 0, 1, 5, 0);
    add(0, 16'h0000, 1, 0, 5, 0);
    // Withdrawal: owner 3 drops in 3rd cycle
    add(0, 16'h1000, 0, 1, 3, 0);
    add(0, 16'h1040, 0, 1, 3, 0);
    add(0, 16'h1040, 0, 1, 3, 0);
    add(0, 16'h0040, 0, 0, 3, 0);
    add(0, 16'h0040, 0, 1, 9, 0);
    add(0, 16'h0000, 1, 0, 9, 0);
    // Wrap: last=14, req 1 and 15 -> 15
    add(0, 16'h0002, 0, 1, 14, 0);
    add(0, 16'h0002, 1, 0, 14, 0);
    add(0, 16'h4001, 0, 1, 15, 0);
    for (int c = 0; c < 7; c++) add(0, 16'h4001, 0, 1, 15, 0);
    add(0, 16'h4001, 1, 0, 15, 0);
    // Reset mid-grant of owner 7
    add(0, 16'h0000, 0, 0, 15, 0);
    add(0, 16'h0100, 0, 1, 7, 0);
    add(1, 16'h0100, 0, 0, 0, 0);
    add(0, 16'h2100, 0, 1, 2, 0);
    add(0, 16'h2100, 1, 0, 2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].l);
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].et);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [0:15] q;
      bit r, l;
      case ($urandom_range(3))
        0: q = 16'($urandom);
        1: q = 16'(1) << $urandom_range(15);
        2: q = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: q = 16'hFFFF;
      endcase
      l = ($urandom_range(7) == 0);
      r = ($urandom_range(99) == 0);
      step(r, q, l);
      chk_all($sformatf("rnd%0d", n), m_busy != 0, m_owner, m_to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_sched416.md
# rr_sched416

Round-robin grant scheduler that shares one 16-way resource among 16 requesters. Each cycle in which the resource is free, it picks one pending requester in rotating priority order and holds the grant until that owner releases it or a hold limit expires. It drives the granted index through a 4→16 one-hot decoder so that exactly one grant line is active. It sits between the requester bank and the decoded resource select.

## Interface
- MAX_HOLD, default 8: maximum number of cycles one grant may stay active, legal range 1..255.
- CW, default 8: width of the hold counter; must satisfy 2^CW > MAX_HOLD.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  [0:15]  request lines; req[k] high means requester k wants the resource.
- rel  in  1  release strobe from the current owner; ignored when gnt_vld is low.
- gnt  out  [0:15]  one-hot grant; gnt[k] high means requester k owns the resource; all zero when no grant is active.
- gnt_idx  out  [0:3]  binary index of the owner; gnt_idx[0] is the LSB.
- gnt_vld  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is revoked because it reached MAX_HOLD.

## Operation
- Two states: IDLE and GRANT.
- Reset values:
  - state = IDLE, gnt_vld = 0, gnt = 0, gnt_idx = 0, timeout = 0.
  - hold counter = 0.
  - last-owner pointer = 15, so requester 0 has top priority after reset.
- IDLE:
  - If req is nonzero, pick the first k with req[k] = 1, scanning last+1, last+2, …, wrapping modulo 16 and ending at last itself.
  - On that edge: gnt_idx ← k, gnt_vld ← 1, hold counter ← 1, last ← k, go to GRANT.
  - If req is zero, stay in IDLE with all outputs low.
- GRANT: the grant ends on the next edge if any of the following holds:
  - (a) rel = 1;
  - (b) req[gnt_idx] = 0, meaning the owner withdrew;
  - (c) hold counter = MAX_HOLD.
  - When it ends: gnt_vld ← 0 and state ← IDLE. timeout ← 1 only when (c) is true and neither (a) nor (b) is; in every other cycle timeout ← 0.
  - Otherwise the hold counter increments and the grant persists.
- When the grant ends, gnt_idx keeps its last value; consumers qualify it with gnt_vld.
- gnt = decoded gnt_idx when gnt_vld = 1, otherwise 0.
- Fairness: the just-served requester has the lowest priority at the next arbitration. If it is the only requester, it is granted again.
- Requests arriving while in GRANT wait for the next IDLE cycle; they are never preempted in.
- rst asserted mid-grant: all outputs and the pointer return to their reset values on that edge, with no timeout pulse.

## Timing
- Arbitration latency: a request seen in IDLE at edge n gives gnt_vld = 1 after edge n, i.e. one cycle.
- A hold lasts at least 1 and at most MAX_HOLD cycles of gnt_vld = 1.
- There is always exactly one IDLE cycle (gnt_vld = 0) between two consecutive grants, even back to back. The maximum grant rate is one grant per 2 cycles.
- rel, req and the hold counter are sampled on the same edge. When several end conditions are true at once, the grant ends once and timeout follows the rule above.
- timeout is high during the first IDLE cycle after the revoked grant.
- gnt is combinational from the registered gnt_idx and gnt_vld: no extra latency and no glitch source from req.

## Structure
- Shared include file holds:
  - the state encodings (IDLE = 1'b0, GRANT = 1'b1);
  - the requester count constant 16;
  - the index width constant 4.
- Sub-module: the existing decode416 is instantiated for gnt_idx → one-hot, with its output ANDed with gnt_vld.
- The round-robin search is a combinational priority function over req rotated by last+1. It is kept in this module; no separate sub-module.

## Test plan
- **Reset:** rst high for 2 cycles with req = 16'hFFFF → gnt = 0, gnt_vld = 0, timeout = 0. After rst drops, the first grant is idx 0, gnt = 1000_0000_0000_0000 ([0:15] order).
- **Rotation:** all 16 requesters held high, owner pulses rel each grant cycle → grants go to idx 0, 1, 2, …, 15, 0 on successive 2-cycle slots.
- **Timeout:** MAX_HOLD = 8, req[5] held high, no rel → gnt_vld is high for exactly 8 cycles, then timeout = 1 for one cycle with gnt_vld = 0. idx 5 is re-granted on the next cycle.
- **Withdrawal:** req[3] drops on the 3rd grant cycle → gnt_vld falls on the next edge, timeout stays 0, and the next pending requester (req[9]) is granted one cycle later.
- **Wrap and simultaneity:** last = 14, req[1] and req[15] high → idx 15 is granted. Then rel = 1 and counter = MAX_HOLD on the same edge → grant ends and timeout stays 0.
- **Reset mid-grant:** rst asserted while owner 7 holds → next edge has gnt = 0 and timeout = 0. After reset, with req[7] and req[2] pending, idx 2 is granted, not 7.
